// File: rtl/fault_retry_controller.sv
// ----------------------------------------------------------------------------
// fault_retry_controller
//
// Auto-recovery sequencer between the glitch-filtered fault flag and the
// relay / red-LED outputs. A confirmed fault opens the relay and starts a
// cooldown. The relay is then re-closed for a probe window. A fault-free probe
// window returns the block to normal operation. After MAX_RETRIES failed
// attempts the block latches a lockout, which only an operator clear releases.
//
// Parameters
//   COOLDOWN_CYCLES  cycles the relay is held open per trip before probing (>=1)
//   PROBE_CYCLES     fault-free cycles needed in PROBE to return to NORMAL (>=1)
//   MAX_RETRIES      cooldown/probe attempts allowed before LOCKOUT (1..15)
//
// Ports
//   clk            in   1  system clock
//   reset          in   1  asynchronous, active-low reset
//   true_fault     in   1  glitch-filtered fault flag, synchronous to clk
//   clear_lockout  in   1  operator clear, level-sampled, used only in LOCKOUT
//   relay_enable   out  1  1 = relay closed (load powered)
//   fault_led_en   out  1  1 = red LED blinker enabled (any state but NORMAL)
//   lockout        out  1  1 = in LOCKOUT
//   retry_count    out  4  trips since the last NORMAL (saturates at MAX_RETRIES)
//   state_out      out  3  current state encoding (debug)
// ----------------------------------------------------------------------------
module fault_retry_controller #(
    parameter int unsigned COOLDOWN_CYCLES = 50000,
    parameter int unsigned PROBE_CYCLES    = 1000,
    parameter int unsigned MAX_RETRIES     = 3
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       true_fault,
    input  logic       clear_lockout,
    output logic       relay_enable,
    output logic       fault_led_en,
    output logic       lockout,
    output logic [3:0] retry_count,
    output logic [2:0] state_out
);

    localparam int unsigned TIMER_MAX =
        (COOLDOWN_CYCLES > PROBE_CYCLES) ? COOLDOWN_CYCLES : PROBE_CYCLES;
    localparam int unsigned TW = $clog2(TIMER_MAX + 1);

    localparam logic [TW-1:0] COOLDOWN_LAST = TW'(COOLDOWN_CYCLES - 1);
    localparam logic [TW-1:0] PROBE_LAST    = TW'(PROBE_CYCLES - 1);
    localparam logic [3:0]    RETRY_LIMIT   = 4'(MAX_RETRIES);

    typedef enum logic [2:0] {
        S_NORMAL   = 3'd0,
        S_TRIP     = 3'd1,
        S_COOLDOWN = 3'd2,
        S_PROBE    = 3'd3,
        S_LOCKOUT  = 3'd4
    } state_t;

    state_t        state_q, state_d;
    logic [TW-1:0] timer_q, timer_d;
    logic [3:0]    retry_q, retry_d;

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        timer_d = timer_q;
        retry_d = retry_q;

        case (state_q)
            S_NORMAL: begin
                timer_d = '0;
                if (true_fault) begin
                    state_d = S_TRIP;
                end
            end

            // Single-cycle state: either gives up or books another attempt.
            S_TRIP: begin
                timer_d = '0;
                if (retry_q == RETRY_LIMIT) begin
                    state_d = S_LOCKOUT;
                end else begin
                    retry_d = retry_q + 4'd1;
                    state_d = S_COOLDOWN;
                end
            end

            // Fault input deliberately ignored while the relay is open.
            S_COOLDOWN: begin
                if (timer_q == COOLDOWN_LAST) begin
                    timer_d = '0;
                    state_d = S_PROBE;
                end else begin
                    timer_d = timer_q + TW'(1);
                end
            end

            // A fault wins over window completion, even on the last cycle.
            S_PROBE: begin
                if (true_fault) begin
                    timer_d = '0;
                    state_d = S_TRIP;
                end else if (timer_q == PROBE_LAST) begin
                    timer_d = '0;
                    retry_d = '0;
                    state_d = S_NORMAL;
                end else begin
                    timer_d = timer_q + TW'(1);
                end
            end

            // Clear is level-sensitive; a held clear releases once the fault drops.
            S_LOCKOUT: begin
                timer_d = '0;
                if (clear_lockout && !true_fault) begin
                    retry_d = '0;
                    state_d = S_NORMAL;
                end
            end

            // Unreachable encodings recover to a clean NORMAL.
            default: begin
                state_d = S_NORMAL;
                timer_d = '0;
                retry_d = '0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_NORMAL;
            timer_q <= '0;
            retry_q <= '0;
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
            retry_q <= retry_d;
        end
    end

    // ------------------------------------------------------------------
    // Moore output decode (state register only)
    // ------------------------------------------------------------------
    always_comb begin
        relay_enable = 1'b0;
        fault_led_en = 1'b1;
        lockout      = 1'b0;
        case (state_q)
            S_NORMAL: begin
                relay_enable = 1'b1;
                fault_led_en = 1'b0;
            end
            S_PROBE: begin
                relay_enable = 1'b1;
            end
            S_LOCKOUT: begin
                lockout = 1'b1;
            end
            default: begin
                relay_enable = 1'b0;
            end
        endcase
    end

    assign retry_count = retry_q;
    assign state_out   = state_q;

endmodule

// File: tb/tb_fault_retry_controller.sv
// ----------------------------------------------------------------------------
// Bench for fault_retry_controller with COOLDOWN_CYCLES=8, PROBE_CYCLES=4,
// MAX_RETRIES=2. Inputs change on the falling edge; outputs are sampled on the
// following falling edge (or 1 time unit after an asynchronous reset edge).
// ----------------------------------------------------------------------------
module tb_fault_retry_controller;

    localparam int unsigned CD  = 8;
    localparam int unsigned PR  = 4;
    localparam int unsigned MAXR = 2;

    logic       clk;
    logic       reset;
    logic       true_fault;
    logic       clear_lockout;
    logic       relay_enable;
    logic       fault_led_en;
    logic       lockout;
    logic [3:0] retry_count;
    logic [2:0] state_out;

    int n_cmp = 0;
    int n_bad = 0;

    fault_retry_controller #(
        .COOLDOWN_CYCLES(CD),
        .PROBE_CYCLES   (PR),
        .MAX_RETRIES    (MAXR)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .true_fault   (true_fault),
        .clear_lockout(clear_lockout),
        .relay_enable (relay_enable),
        .fault_led_en (fault_led_en),
        .lockout      (lockout),
        .retry_count  (retry_count),
        .state_out    (state_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ------------------------------------------------------------------
    // Vector table: inputs for one cycle, expected outputs after the edge
    // ------------------------------------------------------------------
    typedef struct {
        logic       f;
        logic       c;
        logic       relay;
        logic       led;
        logic       lock;
        logic [3:0] rc;
        logic [2:0] st;
    } vec_t;

    vec_t vq[$];

    function automatic logic [6:0] pack_exp(input logic [2:0] st, input logic [3:0] rc);
        logic relay, led, lock;
        relay = (st == 3'd0) || (st == 3'd3);
        led   = (st != 3'd0);
        lock  = (st == 3'd4);
        return {relay, led, lock, rc};
    endfunction

    task automatic add(input logic f, input logic c, input logic [2:0] st,
                       input logic [3:0] rc, input int n);
        vec_t v;
        logic [6:0] e;
        e = pack_exp(st, rc);
        v.f = f; v.c = c; v.st = st; v.rc = rc;
        v.relay = e[6]; v.led = e[5]; v.lock = e[4];
        for (int i = 0; i < n; i++) vq.push_back(v);
    endtask

    task automatic check(input string name, input logic [2:0] st, input logic [3:0] rc);
        logic [6:0] e;
        e = pack_exp(st, rc);
        n_cmp++;
        if ({state_out, relay_enable, fault_led_en, lockout, retry_count} !== {st, e}) begin
            n_bad++;
            $display("FAIL %s: got st=%0d relay=%b led=%b lock=%b rc=%0d, want st=%0d relay=%b led=%b lock=%b rc=%0d",
                     name, state_out, relay_enable, fault_led_en, lockout, retry_count,
                     st, e[6], e[5], e[4], rc);
        end
    endtask

    // ------------------------------------------------------------------
    // Reference model: phases with a countdown of cycles left
    // ------------------------------------------------------------------
    int m_phase;   // 0 normal, 1 trip, 2 cooldown, 3 probe, 4 lockout
    int m_left;
    int m_trips;

    task automatic model_reset();
        m_phase = 0; m_left = 0; m_trips = 0;
    endtask

    task automatic model_edge(input logic f, input logic c);
        case (m_phase)
            0: if (f) m_phase = 1;
            1: begin
                if (m_trips == MAXR) m_phase = 4;
                else begin
                    m_trips++;
                    m_phase = 2;
                    m_left  = CD;
                end
            end
            2: begin
                m_left--;
                if (m_left == 0) begin
                    m_phase = 3;
                    m_left  = PR;
                end
            end
            3: begin
                if (f) m_phase = 1;
                else begin
                    m_left--;
                    if (m_left == 0) begin
                        m_phase = 0;
                        m_trips = 0;
                    end
                end
            end
            default: if (c && !f) begin
                m_phase = 0;
                m_trips = 0;
            end
        endcase
    endtask

    initial begin
        int low_cnt;
        logic [3:0] rc_seen;

        reset = 1'b0; true_fault = 1'b0; clear_lockout = 1'b0;
        repeat (2) @(negedge clk);
        check("reset_state", 3'd0, 4'd0);
        reset = 1'b1;

        // Single-cycle fault pulse: 1 TRIP + 8 COOLDOWN, 4 PROBE, NORMAL
        add(1, 0, 3'd1, 4'd0, 1);
        add(0, 0, 3'd2, 4'd1, CD);
        add(0, 0, 3'd3, 4'd1, PR);
        add(0, 0, 3'd0, 4'd0, 1);
        // Fault held: two attempts then LOCKOUT
        add(1, 0, 3'd1, 4'd0, 1);
        add(1, 0, 3'd2, 4'd1, CD);
        add(1, 0, 3'd3, 4'd1, 1);
        add(1, 0, 3'd1, 4'd1, 1);
        add(1, 0, 3'd2, 4'd2, CD);
        add(1, 0, 3'd3, 4'd2, 1);
        add(1, 0, 3'd1, 4'd2, 1);
        add(1, 0, 3'd4, 4'd2, 2);
        // Clear with fault present is ignored, clear after fault drops releases
        add(1, 1, 3'd4, 4'd2, 2);
        add(0, 1, 3'd0, 4'd0, 1);
        add(0, 1, 3'd0, 4'd0, 1);
        // Fault on the last PROBE cycle re-trips
        add(1, 0, 3'd1, 4'd0, 1);
        add(0, 0, 3'd2, 4'd1, CD);
        add(0, 0, 3'd3, 4'd1, PR);
        add(1, 0, 3'd1, 4'd1, 1);
        add(0, 0, 3'd2, 4'd2, CD);
        add(0, 0, 3'd3, 4'd2, PR);
        add(0, 0, 3'd0, 4'd0, 1);

        foreach (vq[i]) begin
            true_fault    = vq[i].f;
            clear_lockout = vq[i].c;
            @(negedge clk);
            n_cmp++;
            if ({state_out, relay_enable, fault_led_en, lockout, retry_count} !==
                {vq[i].st, vq[i].relay, vq[i].led, vq[i].lock, vq[i].rc}) begin
                n_bad++;
                $display("FAIL vec[%0d]: got st=%0d relay=%b led=%b lock=%b rc=%0d, want st=%0d relay=%b led=%b lock=%b rc=%0d",
                         i, state_out, relay_enable, fault_led_en, lockout, retry_count,
                         vq[i].st, vq[i].relay, vq[i].led, vq[i].lock, vq[i].rc);
            end
        end
        true_fault = 1'b0; clear_lockout = 1'b0;

        // Mid-run reset out of LOCKOUT takes effect without a clock edge
        true_fault = 1'b1;
        repeat (22) @(negedge clk);
        check("reach_lockout", 3'd4, 4'd2);
        true_fault = 1'b0;
        #2 reset = 1'b0;
        #1 check("async_reset_lockout", 3'd0, 4'd0);
        @(negedge clk);
        reset = 1'b1;

        // Reset during COOLDOWN at timer=5
        true_fault = 1'b1;
        @(negedge clk);
        true_fault = 1'b0;
        repeat (6) @(negedge clk);
        check("cooldown_t5", 3'd2, 4'd1);
        #2 reset = 1'b0;
        #1 check("async_reset_cooldown", 3'd0, 4'd0);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("after_release", 3'd0, 4'd0);

        // Fresh fault after reset: full 9 relay-open cycles, retry_count=1
        true_fault = 1'b1;
        @(negedge clk);
        true_fault = 1'b0;
        low_cnt = 0;
        rc_seen = 4'd0;
        for (int k = 0; k < 20; k++) begin
            if (!relay_enable) low_cnt++;
            if (state_out == 3'd2) rc_seen = retry_count;
            @(negedge clk);
        end
        n_cmp++;
        if (low_cnt != 1 + CD) begin
            n_bad++;
            $display("FAIL relay_open_cycles: got %0d want %0d", low_cnt, 1 + CD);
        end
        n_cmp++;
        if (rc_seen != 4'd1) begin
            n_bad++;
            $display("FAIL retry_after_reset: got %0d want 1", rc_seen);
        end
        check("recovered", 3'd0, 4'd0);

        // Randomized run against the reference model
        model_reset();
        for (int k = 0; k < 3000; k++) begin
            logic f, c, r;
            f = ($urandom_range(0, 5) == 0);
            c = ($urandom_range(0, 3) == 0);
            r = ($urandom_range(0, 199) != 0);
            true_fault    = f;
            clear_lockout = c;
            reset         = r;
            if (!r) model_reset();
            @(negedge clk);
            if (r) model_edge(f, c);
            check("random", 3'(m_phase), 4'(m_trips));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
